// File: rtl/lstm_seq_driver.sv
// Sequences host samples through an external LSTM cell, one recurrent timestep in flight at a time.
// Optional feature: define LSTM_SEQ_STATE_CLEAR_EN to zero h/C after each last-tagged timestep.
module lstm_seq_driver #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic signed [WIDTH-1:0] s_data,
    input  logic                    s_valid,
    output logic                    s_ready,
    input  logic                    s_last,
    output logic signed [WIDTH-1:0] x_in,
    output logic                    x_valid,
    input  logic                    x_ready,
    output logic signed [WIDTH-1:0] h_in,
    output logic signed [WIDTH-1:0] C_in,
    input  logic signed [WIDTH-1:0] y_out,
    input  logic signed [WIDTH-1:0] C_out,
    input  logic                    y_valid,
    output logic signed [WIDTH-1:0] m_data,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic                    m_last,
    output logic [15:0]             step_cnt,
    output logic                    err_unexp
);

    localparam int unsigned AW = $clog2(DEPTH);

    typedef enum logic [1:0] {StIdle, StIssue, StWait} state_e;

    state_e state_q, state_d;

    // Sample FIFO: extra pointer bit distinguishes full from empty.
    logic [WIDTH:0]  mem [DEPTH];
    logic [AW:0]     wr_ptr_q, rd_ptr_q;
    logic            full, empty, push, pop;
    logic [WIDTH:0]  head;
    logic            init_q;

    logic                    last_tag_q;
    logic                    capture;
    logic                    clr_q;
    logic signed [WIDTH-1:0] h_q, c_q;
    logic signed [WIDTH-1:0] m_data_q;
    logic                    m_valid_q, m_last_q;
    logic [15:0]             step_q;
    logic                    err_q;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign head  = mem[rd_ptr_q[AW-1:0]];

    assign s_ready = init_q && !full;
    assign push    = s_valid && s_ready;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q[AW-1:0]] <= {s_last, s_data};
        end
    end

    // Issue only when the result slot will be free, so a capture never overwrites.
    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        capture = 1'b0;
        x_valid = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (!empty && (!m_valid_q || m_ready)) begin
                    state_d = StIssue;
                end
            end
            StIssue: begin
                x_valid = 1'b1;
                if (x_ready) begin
                    pop     = 1'b1;
                    state_d = StWait;
                end
            end
            StWait: begin
                if (y_valid) begin
                    capture = 1'b1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign x_in      = (state_q == StIssue) ? head[WIDTH-1:0] : '0;
    assign h_in      = h_q;
    assign C_in      = c_q;
    assign m_data    = m_data_q;
    assign m_valid   = m_valid_q;
    assign m_last    = m_last_q;
    assign step_cnt  = step_q;
    assign err_unexp = err_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StIdle;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            init_q     <= 1'b0;
            last_tag_q <= 1'b0;
            clr_q      <= 1'b0;
            h_q        <= '0;
            c_q        <= '0;
            m_data_q   <= '0;
            m_valid_q  <= 1'b0;
            m_last_q   <= 1'b0;
            step_q     <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q <= state_d;
            init_q  <= 1'b1;
            clr_q   <= capture && last_tag_q;

            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q   <= rd_ptr_q + 1'b1;
                last_tag_q <= head[WIDTH];
            end

            if (capture) begin
                m_data_q  <= y_out;
                m_last_q  <= last_tag_q;
                m_valid_q <= 1'b1;
            end else if (m_valid_q && m_ready) begin
                m_valid_q <= 1'b0;
                m_last_q  <= 1'b0;
            end

            if (capture) begin
                step_q <= step_q + 16'd1;
            end else if (clr_q) begin
                step_q <= '0;
            end

            if (capture) begin
                h_q <= y_out;
                c_q <= C_out;
`ifdef LSTM_SEQ_STATE_CLEAR_EN
            end else if (clr_q) begin
                h_q <= '0;
                c_q <= '0;
`endif
            end

            if (y_valid && (state_q != StWait)) begin
                err_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_lstm_seq_driver.sv
// Scoreboard bench for lstm_seq_driver: reference model built from the host sample stream.
module tb_lstm_seq_driver;

    localparam int W = 16;

    logic                clk = 1'b0;
    logic                rst = 1'b0;
    logic signed [W-1:0] s_data = '0;
    logic                s_valid = 1'b0;
    logic                s_ready;
    logic                s_last = 1'b0;
    logic signed [W-1:0] x_in;
    logic                x_valid;
    logic                x_ready = 1'b0;
    logic signed [W-1:0] h_in, c_in;
    logic signed [W-1:0] y_out = '0;
    logic signed [W-1:0] c_out = '0;
    logic                y_valid = 1'b0;
    logic signed [W-1:0] m_data;
    logic                m_valid;
    logic                m_ready = 1'b0;
    logic                m_last;
    logic [15:0]         step_cnt;
    logic                err_unexp;

    lstm_seq_driver #(.WIDTH(W), .DEPTH(8)) dut (
        .clk(clk), .rst(rst),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready), .s_last(s_last),
        .x_in(x_in), .x_valid(x_valid), .x_ready(x_ready),
        .h_in(h_in), .C_in(c_in), .y_out(y_out), .C_out(c_out), .y_valid(y_valid),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last),
        .step_cnt(step_cnt), .err_unexp(err_unexp)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic signed [W-1:0] d;
        logic                last;
        logic [15:0]         step;
    } out_t;

    typedef struct packed {
        logic signed [W-1:0] h;
        logic signed [W-1:0] c;
    } hc_t;

    out_t out_q[$];
    hc_t  hc_q[$];

    int n_checks = 0;
    int n_fail   = 0;

    logic signed [W-1:0] ref_h = '0;
    logic signed [W-1:0] ref_c = '0;
    int  ref_pos  = 0;
    bit  echo     = 1'b0;
    int  xr_mode  = 1;  // 0 random, 1 low, 2 high
    int  mr_mode  = 1;
    bit  lstm_auto = 1'b1;
    bit  inj_req  = 1'b0;
    int  hs_count = 0;
    int  max_lat  = 2;

    // Behaviour of the external cell; echo mode is the simple x+1 / x model.
    function automatic logic signed [W-1:0] f_y(input logic signed [W-1:0] x,
                                                input logic signed [W-1:0] h, input bit e);
        logic signed [W-1:0] one = 1;
        return e ? x + one : x + (h >>> 1) + one;
    endfunction

    function automatic logic signed [W-1:0] f_c(input logic signed [W-1:0] x,
                                                input logic signed [W-1:0] c, input bit e);
        return e ? x : c + x;
    endfunction

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    task automatic ref_push(input logic signed [W-1:0] x, input bit last);
        logic signed [W-1:0] y, c;
        out_t o;
        hc_t  e;
        e.h = ref_h;
        e.c = ref_c;
        hc_q.push_back(e);
        y = f_y(x, ref_h, echo);
        c = f_c(x, ref_c, echo);
        ref_pos = (ref_pos + 1) % 65536;
        o.d    = y;
        o.last = last;
        o.step = 16'(ref_pos);
        out_q.push_back(o);
        ref_h = y;
        ref_c = c;
        if (last) begin
            ref_pos = 0;
`ifdef LSTM_SEQ_STATE_CLEAR_EN
            ref_h = '0;
            ref_c = '0;
`endif
        end
    endtask

    task automatic ref_reset();
        out_q.delete();
        hc_q.delete();
        ref_h = '0;
        ref_c = '0;
        ref_pos = 0;
    endtask

    // Called at posedge+1; returns at posedge+1 after the push edge.
    task automatic push(input logic signed [W-1:0] x, input bit last);
        int t = 0;
        s_valid = 1'b1;
        s_data  = x;
        s_last  = last;
        @(negedge clk);
        while (!s_ready && t < 2000) begin
            @(negedge clk);
            t++;
        end
        if (!s_ready) fail_now("push_timeout");
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        ref_push(x, last);
    endtask

    task automatic wait_drain();
        int t = 0;
        while ((out_q.size() != 0 || hc_q.size() != 0) && t < 3000) begin
            @(negedge clk);
            t++;
        end
        if (out_q.size() != 0 || hc_q.size() != 0) fail_now("drain_timeout");
        repeat (3) @(negedge clk);
    endtask

    task automatic do_inject();
        int t = 0;
        inj_req = 1'b1;
        while (inj_req && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (inj_req) fail_now("inject_timeout");
        @(negedge clk);
    endtask

    task automatic lstm_proc();
        logic signed [W-1:0] px, ph, pc;
        hc_t e;
        int  lat;
        forever begin
            @(negedge clk);
            if (inj_req) begin
                @(posedge clk);
                #1;
                y_valid = 1'b1;
                y_out   = 16'sh1234;
                c_out   = 16'sh0567;
                @(posedge clk);
                #1;
                y_valid = 1'b0;
                inj_req = 1'b0;
            end else begin
                case (xr_mode)
                    0:       x_ready = 1'($urandom_range(0, 1));
                    1:       x_ready = 1'b0;
                    default: x_ready = 1'b1;
                endcase
                if (rst && x_valid && x_ready) begin
                    hs_count++;
                    px = x_in;
                    ph = h_in;
                    pc = c_in;
                    if (hc_q.size() == 0) begin
                        fail_now("unexpected_issue");
                    end else begin
                        e = hc_q.pop_front();
                        chk("h_in_at_issue", ph, e.h);
                        chk("C_in_at_issue", pc, e.c);
                    end
                    @(posedge clk);
                    #1;
                    x_ready = 1'b0;
                    if (lstm_auto) begin
                        lat = $urandom_range(0, max_lat);
                        repeat (lat) begin
                            @(posedge clk);
                            #1;
                        end
                        y_valid = 1'b1;
                        y_out   = f_y(px, ph, echo);
                        c_out   = f_c(px, pc, echo);
                        @(posedge clk);
                        #1;
                        y_valid = 1'b0;
                    end
                end
            end
        end
    endtask

    task automatic monitor();
        out_t e;
        forever begin
            @(negedge clk);
            if (rst && m_valid && m_ready) begin
                if (out_q.size() == 0) begin
                    fail_now("unexpected_result");
                end else begin
                    e = out_q.pop_front();
                    chk("m_data", m_data, e.d);
                    chk("m_last", m_last, e.last);
                    if (!e.last) chk("step_cnt_at_pop", step_cnt, e.step);
                end
            end
        end
    endtask

    task automatic mready_drv();
        forever begin
            @(posedge clk);
            #1;
            case (mr_mode)
                0:       m_ready = 1'($urandom_range(0, 1));
                1:       m_ready = 1'b0;
                default: m_ready = 1'b1;
            endcase
        end
    endtask

    initial begin
        logic signed [W-1:0] v0;
        int hs0;
        int t;
        int len;

        fork
            lstm_proc();
            monitor();
            mready_drv();
        join_none

        // Reset values while rst is low
        repeat (3) @(negedge clk);
        chk("rst_s_ready", s_ready, 0);
        chk("rst_x_valid", x_valid, 0);
        chk("rst_m_valid", m_valid, 0);
        chk("rst_x_in", x_in, 0);
        chk("rst_h_in", h_in, 0);
        chk("rst_step_cnt", step_cnt, 0);
        chk("rst_err_unexp", err_unexp, 0);
        rst = 1'b1;
        @(negedge clk);
        chk("s_ready_after_reset", s_ready, 1);

        // Echo sequence 10, 20, 30(last)
        @(posedge clk);
        #1;
        echo = 1'b1;
        xr_mode = 2;
        mr_mode = 2;
        push(16'sd10, 1'b0);
        push(16'sd20, 1'b0);
        push(16'sd30, 1'b1);
        wait_drain();
        chk("step_cnt_after_seq", step_cnt, 0);
        echo = 1'b0;

        // Fill the FIFO while the cell refuses input
        @(posedge clk);
        #1;
        xr_mode = 1;
        v0 = 16'($urandom);
        push(v0, 1'b0);
        for (int i = 1; i < 8; i++) push(16'($urandom), i == 7);
        @(negedge clk);
        chk("s_ready_when_full", s_ready, 0);
        for (int i = 0; i < 3; i++) begin
            chk("x_valid_held", x_valid, 1);
            chk("x_in_stable", x_in, v0);
            @(negedge clk);
        end
        xr_mode = 0;
        mr_mode = 0;
        wait_drain();

        // Output stalled: only one timestep may be issued
        @(posedge clk);
        #1;
        mr_mode = 1;
        xr_mode = 2;
        hs0 = hs_count;
        push(16'($urandom), 1'b0);
        push(16'($urandom), 1'b1);
        repeat (30) @(negedge clk);
        chk("single_outstanding", hs_count - hs0, 1);
        chk("m_valid_held", m_valid, 1);
        mr_mode = 0;
        wait_drain();

        // Randomized multi-sequence traffic
        @(posedge clk);
        #1;
        xr_mode = 0;
        mr_mode = 0;
        max_lat = 3;
        for (int s = 0; s < 4; s++) begin
            len = $urandom_range(3, 12);
            for (int k = 0; k < len; k++) begin
                repeat ($urandom_range(0, 2)) begin
                    @(posedge clk);
                    #1;
                end
                push(16'($urandom), k == len - 1);
            end
        end
        wait_drain();
        chk("step_cnt_after_random", step_cnt, 0);

        // Unexpected y_valid in IDLE
        xr_mode = 1;
        chk("err_clear_before", err_unexp, 0);
        do_inject();
        chk("err_set_idle", err_unexp, 1);
        chk("m_valid_after_unexp", m_valid, 0);
        repeat (5) @(negedge clk);
        chk("err_sticky", err_unexp, 1);

        // Reset while a timestep is outstanding
        @(posedge clk);
        #1;
        lstm_auto = 1'b0;
        xr_mode = 2;
        mr_mode = 2;
        hs0 = hs_count;
        push(16'sd77, 1'b0);
        t = 0;
        while (hs_count == hs0 && t < 100) begin
            @(posedge clk);
            t++;
        end
        if (hs_count == hs0) fail_now("issue_timeout");
        #2;
        rst = 1'b0;
        #1;
        chk("mid_rst_x_valid", x_valid, 0);
        chk("mid_rst_m_valid", m_valid, 0);
        chk("mid_rst_m_last", m_last, 0);
        chk("mid_rst_m_data", m_data, 0);
        chk("mid_rst_s_ready", s_ready, 0);
        chk("mid_rst_C_in", c_in, 0);
        chk("mid_rst_err", err_unexp, 0);
        ref_reset();
        xr_mode = 1;
        lstm_auto = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        do_inject();
        chk("err_after_reset_wait", err_unexp, 1);
        chk("m_valid_no_partial", m_valid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
